// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the P7 five-stage pipeline. Owns the program
//   counter, selects the next PC (sequential, D-stage redirect, eret return,
//   exception vector) and presents the fetched word with its PC, PC+4,
//   delay-slot flag and fetch exception code to the F/D pipeline register.
//
// Ports
//   Clk       in   clock, all state updates on the rising edge
//   Reset     in   synchronous active-high reset, loads RESET_PC
//   PCEn      in   fetch enable, 0 = stall (PC holds)
//   ExcEntry  in   CP0 is entering an exception/interrupt this cycle
//   EretD     in   instruction in D is eret
//   EPC       in   [31:0] return address from CP0
//   NPCSelD   in   D-stage branch/jump redirect taken
//   NPCD      in   [31:0] redirect target from D
//   BranchD   in   instruction in D is a branch/jump (taken or not)
//   InstrIM   in   [31:0] word read from instruction memory at IMAddr
//   IMAddr    out  [31:0] instruction-memory address (= PCF)
//   PCF       out  [31:0] current fetch PC
//   PC4F      out  [31:0] PCF + 4, modulo 2^32
//   InstrF    out  [31:0] fetched word, 0 when squashed or faulting
//   ExcCodeF  out  [6:2]  fetch exception code, 0 = none, 4 = AdEL
//   BDF       out  fetched word sits in a branch delay slot
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCEn,
  input  logic        ExcEntry,
  input  logic        EretD,
  input  logic [31:0] EPC,
  input  logic        NPCSelD,
  input  logic [31:0] NPCD,
  input  logic        BranchD,
  input  logic [31:0] InstrIM,
  output logic [31:0] IMAddr,
  output logic [31:0] PCF,
  output logic [31:0] PC4F,
  output logic [31:0] InstrF,
  output logic [6:2]  ExcCodeF,
  output logic        BDF
);

  localparam logic [6:2] EXC_NONE = 5'd0;
  localparam logic [6:2] EXC_ADEL = 5'd4;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  // Wraps naturally from 32'hFFFF_FFFC to 0.
  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC selection. The exception vector is taken even during a stall;
  // redirects arriving during a stall are dropped because D re-presents them.
  always_comb begin
    // NOTE: a default on every path keeps this purely combinational (no latch).
    pc_d = pc_plus4;
    if (ExcEntry) begin
      pc_d = EXC_VECTOR;
    end else if (!PCEn) begin
      pc_d = pc_q;
    end else if (EretD) begin
      pc_d = EPC;
    end else if (NPCSelD) begin
      pc_d = NPCD;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Bad targets are loaded as-is; the fault appears when the address is fetched.
  assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);

  // The slot after eret is squashed outright, which also hides any fault on it.
  // A faulting fetch still reports BDF so CP0 can form the right EPC.
  always_comb begin
    InstrF   = InstrIM;
    ExcCodeF = EXC_NONE;
    BDF      = BranchD;
    if (EretD) begin
      InstrF = 32'd0;
      BDF    = 1'b0;
    end else if (fetch_fault) begin
      InstrF   = 32'd0;
      ExcCodeF = EXC_ADEL;
    end
  end

  assign PCF    = pc_q;
  assign IMAddr = pc_q;
  assign PC4F   = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Scoreboard bench for fetch_unit. A stimulus process drives one input set
//   per cycle, asks a reference model for the expected outputs and queues
//   them; a monitor process samples the DUT on the falling edge, pops the
//   queue and compares. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT   = 32'h0000_6FFC;

  typedef struct {
    logic        reset;
    logic        pcen;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        npcsel;
    logic [31:0] npcd;
    logic        branch;
    logic [31:0] instr;
  } stim_t;

  typedef struct {
    int          id;
    logic [31:0] pcf;
    logic [31:0] pc4f;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PCEn;
  logic        ExcEntry;
  logic        EretD;
  logic [31:0] EPC;
  logic        NPCSelD;
  logic [31:0] NPCD;
  logic        BranchD;
  logic [31:0] InstrIM;
  logic [31:0] IMAddr;
  logic [31:0] PCF;
  logic [31:0] PC4F;
  logic [31:0] InstrF;
  logic [6:2]  ExcCodeF;
  logic        BDF;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  bit          model_valid = 1'b0;
  int          cycle_id = 0;

  always #5 Clk = ~Clk;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VECTOR),
    .IM_BASE   (IM_BASE),
    .IM_LIMIT  (IM_LIMIT)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .PCEn    (PCEn),
    .ExcEntry(ExcEntry),
    .EretD   (EretD),
    .EPC     (EPC),
    .NPCSelD (NPCSelD),
    .NPCD    (NPCD),
    .BranchD (BranchD),
    .InstrIM (InstrIM),
    .IMAddr  (IMAddr),
    .PCF     (PCF),
    .PC4F    (PC4F),
    .InstrF  (InstrF),
    .ExcCodeF(ExcCodeF),
    .BDF     (BDF)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what F must show for a given PC and set of inputs.
  function automatic exp_t model_outputs(input logic [31:0] pc, input stim_t s, input int id);
    exp_t e;
    bit   bad_addr;
    bad_addr = (pc % 4 != 0) || (pc < IM_BASE) || (pc > IM_LIMIT);
    e.id   = id;
    e.pcf  = pc;
    e.pc4f = pc + 32'd4;
    if (s.eret) begin
      e.instr = 32'd0; e.exc = 5'd0; e.bd = 1'b0;
    end else if (bad_addr) begin
      e.instr = 32'd0; e.exc = 5'd4; e.bd = s.branch;
    end else begin
      e.instr = s.instr; e.exc = 5'd0; e.bd = s.branch;
    end
    return e;
  endfunction

  // Reference model: the PC after the edge, by the documented priority list.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input stim_t s);
    if (s.reset)   return RESET_PC;
    if (s.exc)     return EXC_VECTOR;
    if (!s.pcen)   return pc;
    if (s.eret)    return s.epc;
    if (s.npcsel)  return s.npcd;
    return pc + 32'd4;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.reset = 1'b0; s.pcen = 1'b1; s.exc = 1'b0; s.eret = 1'b0;
    s.epc = 32'd0; s.npcsel = 1'b0; s.npcd = 32'd0; s.branch = 1'b0;
    s.instr = $urandom;
    return s;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = IM_BASE + 32'($urandom_range(0, 4095)) * 32'd4;
    case ($urandom_range(0, 5))
      0, 1, 2: ;
      3:       a = a + 32'($urandom_range(1, 3));
      4: begin
        case ($urandom_range(0, 3))
          0:       a = 32'h0000_2FFC;
          1:       a = 32'h0000_7000;
          2:       a = 32'h0000_0000;
          default: a = 32'hFFFF_FFFC;
        endcase
      end
      default: a = ($urandom_range(0, 1) == 0) ? IM_BASE : IM_LIMIT;
    endcase
    return a;
  endfunction

  // Drive one cycle; inputs change 2 time units after the rising edge.
  task automatic apply(input stim_t s);
    Reset    = s.reset;
    PCEn     = s.pcen;
    ExcEntry = s.exc;
    EretD    = s.eret;
    EPC      = s.epc;
    NPCSelD  = s.npcsel;
    NPCD     = s.npcd;
    BranchD  = s.branch;
    InstrIM  = s.instr;
    cycle_id++;
    if (model_valid) exp_q.push_back(model_outputs(model_pc, s, cycle_id));
    @(posedge Clk);
    if (s.reset) begin
      model_pc    = RESET_PC;
      model_valid = 1'b1;
    end else if (model_valid) begin
      model_pc = model_next(model_pc, s);
    end
    #2;
  endtask

  // Monitor: compares whatever the scoreboard expects for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("c%0d PCF", e.id),      PCF,             e.pcf);
        check($sformatf("c%0d IMAddr", e.id),   IMAddr,          e.pcf);
        check($sformatf("c%0d PC4F", e.id),     PC4F,            e.pc4f);
        check($sformatf("c%0d InstrF", e.id),   InstrF,          e.instr);
        check($sformatf("c%0d ExcCodeF", e.id), 32'(ExcCodeF),   32'(e.exc));
        check($sformatf("c%0d BDF", e.id),      32'(BDF),        32'(e.bd));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;

    // Reset for two cycles, then free-run 0x3000..0x300C.
    s = idle(); s.reset = 1'b1;
    apply(s); apply(s);
    repeat (4) apply(idle());

    // At 0x3010: taken branch, delay slot fetched with BDF=1, then target.
    s = idle(); s.branch = 1'b1; s.npcsel = 1'b1; s.npcd = 32'h0000_3100;
    apply(s);
    // At 0x3100: redirect to 0x3020.
    s = idle(); s.npcsel = 1'b1; s.npcd = 32'h0000_3020;
    apply(s);
    // Stall at 0x3020 with a redirect pending: dropped, PC holds.
    s = idle(); s.pcen = 1'b0; s.npcsel = 1'b1; s.npcd = 32'h0000_3500;
    apply(s); apply(s);
    // Exception while still stalled goes to the vector.
    s.exc = 1'b1;
    apply(s);

    // Misaligned, above-limit and below-base targets each fault when fetched.
    s = idle(); s.npcsel = 1'b1; s.npcd = 32'h0000_3002; apply(s);
    s = idle(); s.npcsel = 1'b1; s.npcd = 32'h0000_7000; apply(s);
    s = idle(); s.npcsel = 1'b1; s.npcd = 32'h0000_2FFC; apply(s);
    s = idle(); s.npcsel = 1'b1; s.npcd = 32'h0000_3030; s.branch = 1'b1; apply(s);

    // eret squashes its slot and wins over a redirect; exception wins over eret.
    s = idle(); s.eret = 1'b1; s.epc = 32'h0000_3040; s.instr = 32'h2401_0001;
    s.npcsel = 1'b1; s.npcd = 32'h0000_3300; s.branch = 1'b1;
    apply(s);
    s.exc = 1'b1; s.epc = 32'h0000_3080;
    apply(s);

    // Reset beats exception and redirect.
    s = idle(); s.reset = 1'b1; s.exc = 1'b1; s.npcsel = 1'b1; s.npcd = 32'h0000_5000;
    apply(s);
    apply(idle());

    // Wrap-around: redirect to the top word, PC4F and next PC become 0.
    s = idle(); s.npcsel = 1'b1; s.npcd = 32'hFFFF_FFFC; apply(s);
    apply(idle());
    apply(idle());

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.reset  = ($urandom_range(0, 99) < 2);
      s.pcen   = ($urandom_range(0, 99) < 80);
      s.exc    = ($urandom_range(0, 99) < 5);
      s.eret   = ($urandom_range(0, 99) < 10);
      s.npcsel = ($urandom_range(0, 99) < 25);
      s.branch = s.npcsel | ($urandom_range(0, 99) < 10);
      s.epc    = rand_addr();
      s.npcd   = rand_addr();
      apply(s);
    end

    @(negedge Clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
